// File: rtl/sdrc_req_arb.sv
// Round-robin merge of NCH application request ports onto the single sdrc_core
// app port; owner FIFOs steer write beats and read returns back to their issuer.
module sdrc_req_arb #(
  parameter int NCH    = 4,
  parameter int APP_AW = 26,
  parameter int bl     = 9,
  parameter int dw     = 32,
  parameter int OD     = 4
) (
  input  logic                    sdram_clk,
  input  logic                    resetn,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH*APP_AW-1:0]   ch_req_addr,
  input  logic [NCH*bl-1:0]       ch_req_len,
  input  logic [NCH-1:0]          ch_req_wr_n,
  output logic [NCH-1:0]          ch_req_ack,
  input  logic [NCH*dw-1:0]       ch_wr_data,
  input  logic [NCH*(dw/8)-1:0]   ch_wr_en_n,
  output logic [NCH-1:0]          ch_wr_next,
  output logic [NCH-1:0]          ch_rd_valid,
  output logic [NCH-1:0]          ch_last_rd,
  output logic [dw-1:0]           ch_rd_data,
  output logic                    app_req,
  output logic [APP_AW-1:0]       app_req_addr,
  output logic [bl-1:0]           app_req_len,
  output logic                    app_req_wr_n,
  input  logic                    app_req_ack,
  output logic [dw-1:0]           app_wr_data,
  output logic [(dw/8)-1:0]       app_wr_en_n,
  input  logic                    app_wr_next_req,
  input  logic [dw-1:0]           app_rd_data,
  input  logic                    app_rd_valid,
  input  logic                    app_last_rd,
  output logic                    arb_err
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(OD);
  localparam int PW = AW + 1;
  localparam int BW = dw / 8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [GW-1:0]     last_grant_r, gnt_r, pick_s, cand_s;
  logic              found_s, grant_s, issue_ack_s;
  logic [NCH-1:0]    elig_s, ch_req_ack_r;
  logic              app_req_r, app_req_wr_n_r;
  logic [APP_AW-1:0] app_req_addr_r;
  logic [bl-1:0]     app_req_len_r;

  logic [GW-1:0]     wf_id_r  [OD];
  logic [bl-1:0]     wf_len_r [OD];
  logic [PW-1:0]     wf_wp_r, wf_rp_r;
  logic [GW-1:0]     rf_id_r  [OD];
  logic [PW-1:0]     rf_wp_r, rf_rp_r;
  logic              wf_empty_s, wf_full_s, rf_empty_s, rf_full_s;
  logic              wf_push_s, wf_pop_s, rf_push_s, rf_pop_s;
  logic [GW-1:0]     wf_head_id_s, rf_head_id_s;
  logic [bl-1:0]     wf_head_len_s, beat_cnt_r;
  logic              wr_hit_s, rd_hit_s, err_s, arb_err_r;

  function automatic logic [NCH-1:0] onehot(input logic [GW-1:0] idx);
    logic [NCH-1:0] v;
    v      = {NCH{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign wf_empty_s    = (wf_wp_r == wf_rp_r);
  assign wf_full_s     = (wf_wp_r[AW] != wf_rp_r[AW]) && (wf_wp_r[AW-1:0] == wf_rp_r[AW-1:0]);
  assign rf_empty_s    = (rf_wp_r == rf_rp_r);
  assign rf_full_s     = (rf_wp_r[AW] != rf_rp_r[AW]) && (rf_wp_r[AW-1:0] == rf_rp_r[AW-1:0]);
  assign wf_head_id_s  = wf_id_r[wf_rp_r[AW-1:0]];
  assign wf_head_len_s = wf_len_r[wf_rp_r[AW-1:0]];
  assign rf_head_id_s  = rf_id_r[rf_rp_r[AW-1:0]];

  assign issue_ack_s = (state_r == ST_ISSUE) && app_req_ack;
  assign grant_s     = (state_r == ST_IDLE) && found_s;
  assign wf_push_s   = issue_ack_s && !app_req_wr_n_r;
  assign rf_push_s   = issue_ack_s && app_req_wr_n_r;
  assign wr_hit_s    = app_wr_next_req && !wf_empty_s;
  assign rd_hit_s    = app_rd_valid && !rf_empty_s;
  assign wf_pop_s    = wr_hit_s && ((beat_cnt_r + {{(bl-1){1'b0}}, 1'b1}) == wf_head_len_s);
  assign rf_pop_s    = rd_hit_s && app_last_rd;
  assign err_s       = (app_wr_next_req && wf_empty_s) || (app_rd_valid && rf_empty_s);

  // Eligibility: requesting and the direction's owner FIFO has room. The
  // cycle the ack pulse is out the acked channel still shows its old request.
  always_comb begin
    elig_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (ch_req_wr_n[i]) begin
        elig_s[i] = ch_req[i] && !rf_full_s && (ch_req_ack_r == {NCH{1'b0}});
      end else begin
        elig_s[i] = ch_req[i] && !wf_full_s && (ch_req_ack_r == {NCH{1'b0}});
      end
    end
  end

  // Round-robin search starting one past the last acknowledged channel.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {GW{1'b0}};
    cand_s  = {GW{1'b0}};
    for (int k = 1; k <= NCH; k++) begin
      cand_s = GW'((int'(last_grant_r) + k) % NCH);
      if (!found_s && elig_s[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // FSM next-state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) state_nxt_s = ST_ISSUE;
        else         state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (app_req_ack) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_ISSUE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, latched request fields, ack pulse and round-robin pointer.
  always_ff @(posedge sdram_clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      gnt_r          <= {GW{1'b0}};
      last_grant_r   <= GW'(NCH - 1);
      app_req_r      <= 1'b0;
      app_req_addr_r <= {APP_AW{1'b0}};
      app_req_len_r  <= {bl{1'b0}};
      app_req_wr_n_r <= 1'b1;
      ch_req_ack_r   <= {NCH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      ch_req_ack_r <= {NCH{1'b0}};
      if (grant_s) begin
        gnt_r          <= pick_s;
        app_req_r      <= 1'b1;
        app_req_addr_r <= ch_req_addr[int'(pick_s)*APP_AW +: APP_AW];
        app_req_len_r  <= ch_req_len[int'(pick_s)*bl +: bl];
        app_req_wr_n_r <= ch_req_wr_n[pick_s];
      end
      if (issue_ack_s) begin
        app_req_r    <= 1'b0;
        ch_req_ack_r <= onehot(gnt_r);
        last_grant_r <= gnt_r;
      end
    end
  end

  // Write owner FIFO: {channel, burst length} per accepted write.
  always_ff @(posedge sdram_clk or negedge resetn) begin
    if (!resetn) begin
      wf_wp_r <= {PW{1'b0}};
      wf_rp_r <= {PW{1'b0}};
      for (int j = 0; j < OD; j++) begin
        wf_id_r[j]  <= {GW{1'b0}};
        wf_len_r[j] <= {bl{1'b0}};
      end
    end else begin
      if (wf_push_s) begin
        wf_id_r[wf_wp_r[AW-1:0]]  <= gnt_r;
        wf_len_r[wf_wp_r[AW-1:0]] <= app_req_len_r;
        wf_wp_r                   <= wf_wp_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (wf_pop_s) wf_rp_r <= wf_rp_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Read owner FIFO: channel per accepted read; popped by the last beat.
  always_ff @(posedge sdram_clk or negedge resetn) begin
    if (!resetn) begin
      rf_wp_r <= {PW{1'b0}};
      rf_rp_r <= {PW{1'b0}};
      for (int j = 0; j < OD; j++) rf_id_r[j] <= {GW{1'b0}};
    end else begin
      if (rf_push_s) begin
        rf_id_r[rf_wp_r[AW-1:0]] <= gnt_r;
        rf_wp_r                  <= rf_wp_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (rf_pop_s) rf_rp_r <= rf_rp_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Write beat counter and sticky routing error.
  always_ff @(posedge sdram_clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt_r <= {bl{1'b0}};
      arb_err_r  <= 1'b0;
    end else begin
      if (wf_pop_s)      beat_cnt_r <= {bl{1'b0}};
      else if (wr_hit_s) beat_cnt_r <= beat_cnt_r + {{(bl-1){1'b0}}, 1'b1};
      if (err_s) arb_err_r <= 1'b1;
    end
  end

  // Zero-latency steering of core data strobes to the owning channel.
  always_comb begin
    app_wr_data = {dw{1'b0}};
    app_wr_en_n = {BW{1'b1}};
    ch_wr_next  = {NCH{1'b0}};
    ch_rd_valid = {NCH{1'b0}};
    ch_last_rd  = {NCH{1'b0}};
    if (!wf_empty_s) begin
      app_wr_data = ch_wr_data[int'(wf_head_id_s)*dw +: dw];
      app_wr_en_n = ch_wr_en_n[int'(wf_head_id_s)*BW +: BW];
    end else begin
      app_wr_data = {dw{1'b0}};
      app_wr_en_n = {BW{1'b1}};
    end
    if (wr_hit_s) ch_wr_next = onehot(wf_head_id_s);
    else          ch_wr_next = {NCH{1'b0}};
    if (rd_hit_s) begin
      ch_rd_valid = onehot(rf_head_id_s);
      ch_last_rd  = app_last_rd ? onehot(rf_head_id_s) : {NCH{1'b0}};
    end else begin
      ch_rd_valid = {NCH{1'b0}};
      ch_last_rd  = {NCH{1'b0}};
    end
  end

  assign ch_rd_data   = app_rd_data;
  assign ch_req_ack   = ch_req_ack_r;
  assign app_req      = app_req_r;
  assign app_req_addr = app_req_addr_r;
  assign app_req_len  = app_req_len_r;
  assign app_req_wr_n = app_req_wr_n_r;
  assign arb_err      = arb_err_r;

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Bench for sdrc_req_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed counts and orders.
module tb_sdrc_req_arb;
  localparam int NCH = 4, AW = 26, BL = 9, DW = 32, OD = 4, BW = 4;

  logic                  sdram_clk = 1'b0;
  logic                  resetn;
  logic [NCH-1:0]        ch_req, ch_req_wr_n, ch_req_ack, ch_wr_next, ch_rd_valid, ch_last_rd;
  logic [NCH*AW-1:0]     ch_req_addr;
  logic [NCH*BL-1:0]     ch_req_len;
  logic [NCH*DW-1:0]     ch_wr_data;
  logic [NCH*BW-1:0]     ch_wr_en_n;
  logic [DW-1:0]         ch_rd_data, app_wr_data, app_rd_data;
  logic                  app_req, app_req_wr_n, app_req_ack, app_wr_next_req;
  logic [AW-1:0]         app_req_addr;
  logic [BL-1:0]         app_req_len;
  logic [BW-1:0]         app_wr_en_n;
  logic                  app_rd_valid, app_last_rd, arb_err;

  sdrc_req_arb #(.NCH(NCH), .APP_AW(AW), .bl(BL), .dw(DW), .OD(OD)) dut (
    .sdram_clk(sdram_clk), .resetn(resetn),
    .ch_req(ch_req), .ch_req_addr(ch_req_addr), .ch_req_len(ch_req_len),
    .ch_req_wr_n(ch_req_wr_n), .ch_req_ack(ch_req_ack),
    .ch_wr_data(ch_wr_data), .ch_wr_en_n(ch_wr_en_n), .ch_wr_next(ch_wr_next),
    .ch_rd_valid(ch_rd_valid), .ch_last_rd(ch_last_rd), .ch_rd_data(ch_rd_data),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n), .app_wr_next_req(app_wr_next_req),
    .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
    .arb_err(arb_err)
  );

  always #5 sdram_clk = ~sdram_clk;

  int n_chk = 0, n_fail = 0;
  int ack_cnt[NCH], wn_cnt[NCH], rv_cnt[NCH], lr_cnt[NCH];
  int glog[$];
  logic [NCH-1:0] hold;
  bit auto_wbeat;

  typedef struct {int id; int len;} wentry_t;
  wentry_t wq[$];
  int rq[$];
  int m_last, m_gnt, m_ackch, m_beats;
  bit m_iss, m_wrn, m_err;
  logic [AW-1:0] m_addr;
  logic [BL-1:0] m_len;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = NCH - 1; m_gnt = 0; m_ackch = -1; m_beats = 0;
    m_iss = 1'b0; m_wrn = 1'b1; m_err = 1'b0; m_addr = '0; m_len = '0;
    wq.delete(); rq.delete();
  endtask

  // Reference model: compare at negedge, then apply the cycle's inputs.
  initial begin
    int id, c, nack, wsz, rsz;
    logic [NCH-1:0] one_v, e_ack, e_wn, e_rv, e_lr;
    logic [DW-1:0] e_wd;
    logic [BW-1:0] e_we;
    one_v = 4'b0001;
    model_reset();
    forever begin
      @(negedge sdram_clk);
      if (!resetn) model_reset();
      e_ack = (m_ackch >= 0) ? (one_v << m_ackch) : 4'b0000;
      e_wd = 32'h0; e_we = 4'hF; e_wn = 4'b0000; e_rv = 4'b0000; e_lr = 4'b0000;
      if (wq.size() > 0) begin
        id = wq[0].id;
        e_wd = ch_wr_data[id*DW +: DW];
        e_we = ch_wr_en_n[id*BW +: BW];
        if (app_wr_next_req) e_wn = one_v << id;
      end
      if (rq.size() > 0 && app_rd_valid) begin
        e_rv = one_v << rq[0];
        if (app_last_rd) e_lr = one_v << rq[0];
      end
      chk("app_req", app_req, m_iss);
      chk("app_req_addr", app_req_addr, m_addr);
      chk("app_req_len", app_req_len, m_len);
      chk("app_req_wr_n", app_req_wr_n, m_wrn);
      chk("ch_req_ack", ch_req_ack, e_ack);
      chk("app_wr_data", app_wr_data, e_wd);
      chk("app_wr_en_n", app_wr_en_n, e_we);
      chk("ch_wr_next", ch_wr_next, e_wn);
      chk("ch_rd_valid", ch_rd_valid, e_rv);
      chk("ch_last_rd", ch_last_rd, e_lr);
      chk("ch_rd_data", ch_rd_data, app_rd_data);
      chk("arb_err", arb_err, m_err);
      if (resetn) begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_req_ack[i]) begin ack_cnt[i]++; glog.push_back(i); end
          if (ch_wr_next[i]) wn_cnt[i]++;
          if (ch_rd_valid[i]) rv_cnt[i]++;
          if (ch_last_rd[i]) lr_cnt[i]++;
        end
        wsz = wq.size(); rsz = rq.size();
        if (app_wr_next_req && wsz == 0) m_err = 1'b1;
        if (app_rd_valid && rsz == 0) m_err = 1'b1;
        if (app_wr_next_req && wsz > 0) begin
          m_beats++;
          if (m_beats == wq[0].len) begin void'(wq.pop_front()); m_beats = 0; end
        end
        if (app_rd_valid && app_last_rd && rsz > 0) void'(rq.pop_front());
        nack = -1;
        if (m_iss) begin
          if (app_req_ack) begin
            if (m_wrn) rq.push_back(m_gnt);
            else wq.push_back('{m_gnt, int'(m_len)});
            nack = m_gnt; m_last = m_gnt; m_iss = 1'b0;
          end
        end else if (m_ackch < 0) begin
          for (int k = 1; k <= NCH && !m_iss; k++) begin
            c = (m_last + k) % NCH;
            if (ch_req[c] && (ch_req_wr_n[c] ? (rsz < OD) : (wsz < OD))) begin
              m_iss = 1'b1; m_gnt = c;
              m_addr = ch_req_addr[c*AW +: AW];
              m_len = ch_req_len[c*BL +: BL];
              m_wrn = ch_req_wr_n[c];
            end
          end
        end
        m_ackch = nack;
      end
    end
  end

  // Core acks immediately; channels drop requests on ack unless held.
  task automatic step();
    @(posedge sdram_clk);
    #1;
    app_req_ack = app_req;
    if (auto_wbeat) app_wr_next_req = |ch_req_ack;
    for (int i = 0; i < NCH; i++) if (ch_req_ack[i] && !hold[i]) ch_req[i] = 1'b0;
    ch_wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    ch_wr_en_n = 16'($urandom());
    app_rd_data = $urandom();
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NCH; i++) begin ack_cnt[i] = 0; wn_cnt[i] = 0; rv_cnt[i] = 0; lr_cnt[i] = 0; end
    glog.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0; ch_req = '0; ch_req_wr_n = '1; ch_req_addr = '0; ch_req_len = '0;
    app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_rd_valid = 1'b0; app_last_rd = 1'b0;
    hold = '0; auto_wbeat = 1'b0;
    step(); step();
    resetn = 1'b1;
    clr_cnt();
  endtask

  task automatic set_ch(input int c, input int addr, input int len, input bit wrn);
    ch_req_addr[c*AW +: AW] = AW'(addr);
    ch_req_len[c*BL +: BL] = BL'(len);
    ch_req_wr_n[c] = wrn;
  endtask

  initial begin
    ch_wr_data = '0; ch_wr_en_n = '1; app_rd_data = '0;
    do_reset();
    chk("reset_app_req_wr_n", app_req_wr_n, 1'b1);
    chk("reset_app_wr_en_n", app_wr_en_n, 4'hF);

    // Single write: ch2, addr 0x40, len 4
    set_ch(2, 32'h40, 4, 1'b0); ch_req[2] = 1'b1;
    step();
    chk("sw_addr", app_req_addr, 26'h40);
    chk("sw_app_req", app_req, 1'b1);
    step(); step();
    for (int b = 0; b < 4; b++) begin app_wr_next_req = 1'b1; step(); end
    app_wr_next_req = 1'b0; step(); step();
    chk("sw_wr_next_cnt", wn_cnt[2], 4);
    chk("sw_ack_cnt", ack_cnt[2], 1);
    chk("sw_wfifo_empty_en_n", app_wr_en_n, 4'hF);
    chk("sw_wfifo_empty_data", app_wr_data, 32'h0);

    // Fairness: all four writes (len 1) held continuously
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, c * 16, 1, 1'b0);
    auto_wbeat = 1'b1; hold = 4'hF; ch_req = 4'hF;
    for (int n = 0; n < 26; n++) step();
    hold = 4'h0; ch_req = 4'h0;
    for (int n = 0; n < 5; n++) step();
    auto_wbeat = 1'b0; app_wr_next_req = 1'b0;
    chk("rr_count", glog.size() >= 8, 1'b1);
    for (int i = 0; i < 8; i++) chk("rr_order", (i < glog.size()) ? glog[i] : -1, i % 4);

    // Interleaved reads: ch1 len 2 then ch3 len 3
    do_reset();
    set_ch(1, 32'h100, 2, 1'b1); set_ch(3, 32'h300, 3, 1'b1); ch_req = 4'b1010;
    for (int n = 0; n < 8; n++) step();
    chk("ir_ack1", ack_cnt[1], 1);
    chk("ir_ack3", ack_cnt[3], 1);
    for (int b = 0; b < 5; b++) begin
      app_rd_valid = 1'b1; app_last_rd = (b == 1 || b == 4); step();
    end
    app_rd_valid = 1'b0; app_last_rd = 1'b0; step();
    chk("ir_rv1", rv_cnt[1], 2);
    chk("ir_lr1", lr_cnt[1], 1);
    chk("ir_rv3", rv_cnt[3], 3);
    chk("ir_lr3", lr_cnt[3], 1);

    // RFIFO full: four reads outstanding from ch2/ch3
    do_reset();
    set_ch(2, 32'h200, 1, 1'b1); set_ch(3, 32'h300, 1, 1'b1);
    hold = 4'b1100; ch_req = 4'b1100;
    for (int n = 0; n < 20; n++) step();
    hold = 4'h0; ch_req = 4'h0; step(); step();
    chk("rf_fill2", ack_cnt[2], 2);
    chk("rf_fill3", ack_cnt[3], 2);
    clr_cnt();
    set_ch(0, 32'h10, 1, 1'b1); set_ch(1, 32'h20, 1, 1'b0); ch_req = 4'b0011;
    for (int n = 0; n < 8; n++) step();
    chk("rf_ch0_blocked", ack_cnt[0], 0);
    chk("rf_ch1_write", ack_cnt[1], 1);
    app_wr_next_req = 1'b1; step(); app_wr_next_req = 1'b0;
    app_rd_valid = 1'b1; app_last_rd = 1'b1; step();
    app_rd_valid = 1'b0; app_last_rd = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("rf_ch0_granted", ack_cnt[0], 1);
    chk("rf_rd_to_ch2", lr_cnt[2], 1);
    chk("rf_wn_ch1", wn_cnt[1], 1);

    // Error: read data with RFIFO empty, then write beat with WFIFO empty
    do_reset();
    app_rd_valid = 1'b1; step(); app_rd_valid = 1'b0;
    app_wr_next_req = 1'b1; step(); app_wr_next_req = 1'b0;
    for (int n = 0; n < 3; n++) step();
    chk("err_sticky", arb_err, 1'b1);
    chk("err_no_rv", rv_cnt[0] + rv_cnt[1] + rv_cnt[2] + rv_cnt[3], 0);
    chk("err_no_wn", wn_cnt[0] + wn_cnt[1] + wn_cnt[2] + wn_cnt[3], 0);
    do_reset();
    chk("err_cleared", arb_err, 1'b0);

    // Mid-burst reset during beat 2 of a len-4 write
    set_ch(2, 32'h44, 4, 1'b0); ch_req[2] = 1'b1;
    step(); step(); step();
    app_wr_next_req = 1'b1; step();
    resetn = 1'b0;
    #1;
    chk("mb_app_req", app_req, 1'b0);
    chk("mb_addr", app_req_addr, 26'h0);
    chk("mb_wr_next", ch_wr_next, 4'b0000);
    chk("mb_en_n", app_wr_en_n, 4'hF);
    do_reset();
    set_ch(0, 32'h8, 1, 1'b0); ch_req[0] = 1'b1;
    step(); step(); step();
    app_wr_next_req = 1'b1; step(); app_wr_next_req = 1'b0; step(); step();
    chk("mb_new_ack", ack_cnt[0], 1);
    chk("mb_new_beat", wn_cnt[0], 1);
    chk("mb_no_err", arb_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
